// File: rtl/osd_ctm_trace_filter_pkg.sv
// Shared definitions for the CTM trace filter: event-word width, field
// offsets and the overflow-record count width.
package osd_ctm_package;

   // Width of the drop count carried in an overflow record
   localparam int OVF_CNT_W = 16;

   // Event word width: {prvchg, jal, jalr, prv[1:0], pc, npc, ts}
   function automatic int ew(input int aw, input int tw);
      return 3 + tw + 2 + 2 * aw;
   endfunction

   // Field offsets (LSB position) within the event word
   function automatic int ts_off(input int aw, input int tw);
      return 0;
   endfunction
   function automatic int npc_off(input int aw, input int tw);
      return tw;
   endfunction
   function automatic int pc_off(input int aw, input int tw);
      return tw + aw;
   endfunction
   function automatic int prv_off(input int aw, input int tw);
      return tw + 2 * aw;
   endfunction
   function automatic int jalr_off(input int aw, input int tw);
      return tw + 2 * aw + 2;
   endfunction
   function automatic int jal_off(input int aw, input int tw);
      return tw + 2 * aw + 3;
   endfunction
   function automatic int prvchg_off(input int aw, input int tw);
      return tw + 2 * aw + 4;
   endfunction

endpackage

// File: rtl/osd_ctm_trace_filter_sat_counter.sv
// Saturating up-counter used for the dropped-event count.
// clr_and_inc restarts the count at 1 (a drop in the same cycle the old
// count is reported); clr restarts it at 0.
module osd_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic             clr_and_inc,
   output logic [WIDTH-1:0] value
);

   // Count register: restart takes precedence over increment, holds at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= '0;
      else if (clr_and_inc)
         value <= WIDTH'(1);
      else if (clr)
         value <= '0;
      else if (inc && (value != '1))
         value <= value + WIDTH'(1);
   end

endmodule

// File: rtl/osd_ctm_trace_filter.sv
// CTM trace filter: qualifies retire-trace beats into jump / privilege-change
// events and registers them into a single-entry valid/ready holding register.
// Events arriving while the register is full are dropped and counted; the
// count is reported as an overflow record ahead of the next event.
// Build option: define OSD_CTM_TRACE_FILTER_RANGE_EN to build the npc window
// comparators; otherwise the window always passes and cfg_range_en,
// cfg_addr_lo and cfg_addr_hi are ignored.
module osd_ctm_trace_filter
   import osd_ctm_package::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int TS_WIDTH   = 32,
   parameter int CNT_WIDTH  = OVF_CNT_W
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    cfg_enable,
   input  logic                                    cfg_range_en,
   input  logic [ADDR_WIDTH-1:0]                   cfg_addr_lo,
   input  logic [ADDR_WIDTH-1:0]                   cfg_addr_hi,
   input  logic                                    trace_valid,
   input  logic                                    trace_jal,
   input  logic                                    trace_jalr,
   input  logic                                    trace_mem,
   input  logic [1:0]                              trace_prv,
   input  logic [ADDR_WIDTH-1:0]                   trace_pc,
   input  logic [ADDR_WIDTH-1:0]                   trace_npc,
   input  logic [TS_WIDTH-1:0]                     timestamp,
   output logic [ew(ADDR_WIDTH, TS_WIDTH)-1:0]     out_data,
   output logic                                    out_overflow,
   output logic                                    out_valid,
   input  logic                                    out_ready
);

   localparam int EW     = ew(ADDR_WIDTH, TS_WIDTH);
   localparam int O_TS   = ts_off(ADDR_WIDTH, TS_WIDTH);
   localparam int O_NPC  = npc_off(ADDR_WIDTH, TS_WIDTH);
   localparam int O_PC   = pc_off(ADDR_WIDTH, TS_WIDTH);
   localparam int O_PRV  = prv_off(ADDR_WIDTH, TS_WIDTH);
   localparam int O_JALR = jalr_off(ADDR_WIDTH, TS_WIDTH);
   localparam int O_JAL  = jal_off(ADDR_WIDTH, TS_WIDTH);
   localparam int O_PCHG = prvchg_off(ADDR_WIDTH, TS_WIDTH);

   logic                 win_ok;
   logic                 jump_q;
   logic                 prv_q;
   logic                 ev;
   logic                 free;
   logic                 cnt_nz;
   logic [1:0]           prv_reg;
   logic [CNT_WIDTH-1:0] drop_cnt;
   logic [EW-1:0]        ev_word;
   logic [EW-1:0]        ovf_word;

`ifdef OSD_CTM_TRACE_FILTER_RANGE_EN
   assign win_ok = !cfg_range_en ||
                   ((cfg_addr_lo <= trace_npc) && (trace_npc <= cfg_addr_hi));
`else
   // Window config is accepted but has no effect in this build
   logic unused_win_cfg;
   assign unused_win_cfg = ^{cfg_range_en, cfg_addr_lo, cfg_addr_hi};
   assign win_ok         = 1'b1;
`endif

   assign jump_q = cfg_enable & trace_valid & ~trace_mem & (trace_jal | trace_jalr) & win_ok;
   assign prv_q  = cfg_enable & (prv_reg != trace_prv);
   assign ev     = jump_q | prv_q;
   assign free   = ~out_valid | out_ready;
   assign cnt_nz = (drop_cnt != '0);

   // Assemble the event word and the overflow record from their fields
   always_comb begin
      ev_word                         = '0;
      ev_word[O_PCHG]                 = prv_q;
      ev_word[O_JAL]                  = trace_jal & jump_q;
      ev_word[O_JALR]                 = trace_jalr & jump_q;
      ev_word[O_PRV +: 2]             = trace_prv;
      ev_word[O_PC +: ADDR_WIDTH]     = trace_pc;
      ev_word[O_NPC +: ADDR_WIDTH]    = trace_npc;
      ev_word[O_TS +: TS_WIDTH]       = timestamp;
      ovf_word                        = '0;
      ovf_word[CNT_WIDTH-1:0]         = drop_cnt;
   end

   // Drop counter: reported count is replaced by 0, or 1 if an event is lost meanwhile
   osd_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (~free & ev),
      .clr         (free & cnt_nz & ~ev),
      .clr_and_inc (free & cnt_nz & ev),
      .value       (drop_cnt)
   );

   // Previous privilege level, tracked even while the filter is disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prv_reg <= 2'b11;
      else
         prv_reg <= trace_prv;
   end

   // Holding register: pending overflow record wins over a new event
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_overflow <= 1'b0;
         out_data     <= '0;
      end else if (free) begin
         if (cnt_nz) begin
            out_valid    <= 1'b1;
            out_overflow <= 1'b1;
            out_data     <= ovf_word;
         end else if (ev) begin
            out_valid    <= 1'b1;
            out_overflow <= 1'b0;
            out_data     <= ev_word;
         end else begin
            out_valid    <= 1'b0;
         end
      end
   end

endmodule

// File: doc/osd_ctm_trace_filter.md
Name: osd_ctm_trace_filter

Overview:
- Upstream neighbour of the core control-transfer monitor (CTM) trace path. Sits between the CPU trace port and the CTM sample/FIFO stage.
- Qualifies raw retire-trace beats into CTM events: jal/jalr jumps, optionally restricted to a target-address window, plus privilege-mode changes.
- Registers each event into a single-entry output holding register with a valid/ready handshake.
- Drops events on backpressure, counts the drops, and reports them with an overflow record before the next event.

Parameters:
- ADDR_WIDTH, 64, width of pc/npc/addresses.
- TS_WIDTH, 32, timestamp width carried in each event.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_enable  in  1  0 = no events qualify
- cfg_range_en  in  1  enable the npc window filter on jumps
- cfg_addr_lo  in  ADDR_WIDTH  window low bound, inclusive
- cfg_addr_hi  in  ADDR_WIDTH  window high bound, inclusive
- trace_valid, trace_jal, trace_jalr, trace_mem  in  1 each  CPU trace qualifiers
- trace_prv  in  2  current privilege level
- trace_pc, trace_npc  in  ADDR_WIDTH  retired pc, next pc
- timestamp  in  TS_WIDTH  free-running time
- out_data  out  EW  event word, EW = 3+TS_WIDTH+2+2*ADDR_WIDTH
- out_overflow  out  1  1 = overflow record; drop count in out_data[CNT_WIDTH-1:0], other bits 0
- out_valid  out  1  holding register full
- out_ready  in  1  consumer accepts when out_valid & out_ready

Behaviour:
- Reset values:
  - out_valid=0, out_overflow=0, out_data=0.
  - Drop count=0.
  - prv_reg=2'b11.
- Qualification (combinational, same cycle as the trace beat):
  - jump_q = cfg_enable & trace_valid & !trace_mem & (trace_jal | trace_jalr) & win_ok.
  - win_ok = !cfg_range_en | (cfg_addr_lo <= trace_npc <= cfg_addr_hi), unsigned compare.
  - prv_q = cfg_enable & (prv_reg != trace_prv).
  - prv_reg <= trace_prv every cycle, regardless of cfg_enable.
  - ev = jump_q | prv_q.
- Event word: {prv_q, trace_jal & jump_q, trace_jalr & jump_q, trace_prv, trace_pc, trace_npc, timestamp}, MSB first.
- Latency: an event on cycle N appears on out_valid at cycle N+1.
- Free condition: free = !out_valid | out_ready.
- Priority when free:
  1. Drop count != 0: load an overflow record (out_overflow=1, data = count). If ev is asserted that cycle, it is dropped and count becomes 1; otherwise count becomes 0.
  2. Else if ev: load the event (out_overflow=0).
  3. Else: out_valid <= 0.
- When not free and ev is asserted: the event is dropped and count <= count+1, saturating at 2^CNT_WIDTH-1.
- out_data and out_overflow hold stable while out_valid & !out_ready.
- Reset mid-operation: the held event and the drop count are discarded; no overflow record follows reset.
- A config change applies on the next trace beat; events already held are unaffected.

Optional Feature:
- OSD_CTM_TRACE_FILTER_RANGE_EN defined: the window comparators are built as described.
- Undefined: win_ok is tied to 1, cfg_range_en/cfg_addr_lo/cfg_addr_hi are ignored, and no comparator logic is built. The ports stay present.

Decomposition:
- Shared package osd_ctm_package holds:
  - the EW localparam function;
  - field-offset constants (PRVCHG, JAL, JALR, PRV, PC, NPC, TS);
  - the overflow-record count-field width.
- One sub-module: osd_sat_counter (parameterised width; inc, clr, clr_and_inc inputs; saturating value output) for the drop counter.

Test Plan:
- cfg_enable=1, range off, jal with pc=0x1000, npc=0x2000, ts=5, out_ready=1 -> next cycle out_valid=1, out_overflow=0, jal bit=1, npc=0x2000, ts=5.
- Window lo=0x2000, hi=0x2FFF:
  - jalr npc=0x3000 -> no event;
  - npc=0x2FFF -> event;
  - with macro undefined, both produce events.
- trace_prv changes 3->0 with no jump -> one event with prvchg=1, jal=jalr=0, prv=0; prv held at 0 afterwards -> no further events.
- out_ready=0, one event held, then 5 further jumps -> held event stable, count=5. Raise out_ready -> held event accepted, then overflow record data=5, then the next event.
- out_ready=0 for 70000 qualifying jumps -> overflow record count=0xFFFF (saturated).
- Assert rst while an event is held and count=3 -> out_valid=0 immediately (async); after reset release no overflow record is emitted.
